// File: rtl/dual_ram_be_mp_if.sv
// Bus bundle for dual_ram_be_mp: one byte-enabled write port and NRP packed read ports.
interface dual_ram_be_mp_if #(
    parameter int DW  = 32,
    parameter int AW  = 12,
    parameter int NRP = 2
);
    localparam int BW = DW / 8;

    logic              wen;
    logic [BW-1:0]     w_be_i;
    logic [AW-1:0]     w_addr_i;
    logic [DW-1:0]     w_data_i;
    logic [NRP-1:0]    ren;
    logic [NRP*AW-1:0] r_addr_i;
    logic [NRP*DW-1:0] r_data_o;
    logic [NRP-1:0]    r_valid_o;

    modport master (
        output wen, w_be_i, w_addr_i, w_data_i, ren, r_addr_i,
        input  r_data_o, r_valid_o
    );

    modport slave (
        input  wen, w_be_i, w_addr_i, w_data_i, ren, r_addr_i,
        output r_data_o, r_valid_o
    );
endinterface

// File: rtl/dual_ram_be_mp.sv
// Multi-read-port RAM with byte-enabled write and same-edge write-to-read bypass.
// Define DUAL_RAM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module dual_ram_be_mp #(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int MEM_NUM = 4096,
    parameter int NRP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    dual_ram_be_mp_if.slave  bus
);
    localparam int BW = DW / 8;
    localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    localparam logic [AW:0] MEM_LIM = (AW + 1)'(MEM_NUM);

    logic [DW-1:0] mem [MEM_NUM];

    logic [DW-1:0] w_mask;
    logic          w_ok;

    assign w_ok = rst && bus.wen && ({1'b0, bus.w_addr_i} < MEM_LIM);

    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_mask
            assign w_mask[8*gi +: 8] = {8{bus.w_be_i[gi]}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_ok) begin
            for (int k = 0; k < BW; k++) begin
                if (bus.w_be_i[k]) begin
                    mem[bus.w_addr_i[IW-1:0]][8*k +: 8] <= bus.w_data_i[8*k +: 8];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NRP; gi++) begin : g_port
            logic [AW-1:0] ra;
            logic          r_ok;
            logic          byp_hit;
            logic [DW-1:0] raw_reg;
            logic [DW-1:0] byp_mask_reg;
            logic [DW-1:0] byp_data_reg;
            logic          valid_reg;
            logic [DW-1:0] merged;

            assign ra      = bus.r_addr_i[gi*AW +: AW];
            assign r_ok    = ({1'b0, ra} < MEM_LIM);
            assign byp_hit = w_ok && (ra == bus.w_addr_i);

            // raw_reg holds the pre-write word; the write bytes seen on the same edge
            // are kept alongside so later writes cannot leak into presented data.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    raw_reg      <= '0;
                    byp_mask_reg <= '0;
                    byp_data_reg <= '0;
                    valid_reg    <= 1'b0;
                end else begin
                    valid_reg <= bus.ren[gi];
                    if (bus.ren[gi]) begin
                        raw_reg      <= r_ok ? mem[ra[IW-1:0]] : '0;
                        byp_mask_reg <= byp_hit ? w_mask : '0;
                        byp_data_reg <= bus.w_data_i;
                    end
                end
            end

            assign merged = (raw_reg & ~byp_mask_reg) | (byp_data_reg & byp_mask_reg);

`ifdef DUAL_RAM_OUTREG_EN
            logic [DW-1:0] out_data_reg;
            logic          out_valid_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    out_data_reg  <= '0;
                    out_valid_reg <= 1'b0;
                end else begin
                    out_valid_reg <= valid_reg;
                    if (valid_reg) begin
                        out_data_reg <= merged;
                    end
                end
            end

            assign bus.r_data_o[gi*DW +: DW] = out_data_reg;
            assign bus.r_valid_o[gi]         = out_valid_reg;
`else
            assign bus.r_data_o[gi*DW +: DW] = merged;
            assign bus.r_valid_o[gi]         = valid_reg;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_dual_ram_be_mp.sv
// Self-checking bench for dual_ram_be_mp: reference memory model plus per-port scoreboard.
module tb_dual_ram_be_mp;
    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int MEM_NUM = 3000;
    localparam int NRP     = 2;
`ifdef DUAL_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_ram_be_mp_if #(.DW(DW), .AW(AW), .NRP(NRP)) bus ();

    dual_ram_be_mp #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM), .NRP(NRP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [1:0]  ren;
        logic [11:0] ra0;
        logic [11:0] ra1;
        logic [1:0]  use_e;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    exp_t        sb [NRP][$];
    logic [31:0] model [MEM_NUM];
    logic [31:0] last_data [NRP];
    int unsigned edge_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    vec_t        tbl [$];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic wen, input logic [3:0] be, input logic [11:0] wa,
                                input logic [31:0] wd, input logic [1:0] ren,
                                input logic [11:0] ra0, input logic [11:0] ra1,
                                input logic [1:0] use_e, input logic [31:0] e0,
                                input logic [31:0] e1);
        vec_t v;
        v.wen = wen; v.be = be; v.wa = wa; v.wd = wd; v.ren = ren;
        v.ra0 = ra0; v.ra1 = ra1; v.use_e = use_e; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input int p, input logic [31:0] got,
                         input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s port%0d edge %0d: got %h expected %h", name, p, edge_cnt, got, exp_v);
        end
    endtask

    task automatic step(input logic rst_v, input vec_t v);
        logic [11:0] ra [NRP];
        logic [31:0] ev [NRP];
        logic [31:0] e;
        logic [31:0] got;
        ra[0] = v.ra0; ra[1] = v.ra1;
        ev[0] = v.e0;  ev[1] = v.e1;

        rst          = rst_v;
        bus.wen      = v.wen;
        bus.w_be_i   = v.be;
        bus.w_addr_i = v.wa;
        bus.w_data_i = v.wd;
        bus.ren      = v.ren;
        bus.r_addr_i = {v.ra1, v.ra0};

        if (rst_v) begin
            for (int p = 0; p < NRP; p++) begin
                if (v.ren[p]) begin
                    if (int'(ra[p]) >= MEM_NUM) e = 32'h0;
                    else if (v.wen && v.wa == ra[p]) e = merge(model[ra[p]], v.wd, v.be);
                    else e = model[ra[p]];
                    if (v.use_e[p]) e = ev[p];
                    sb[p].push_back('{edge_cnt + LAT, e});
                end
            end
            if (v.wen && int'(v.wa) < MEM_NUM) model[v.wa] = merge(model[v.wa], v.wd, v.be);
        end

        @(posedge clk);
        edge_cnt++;
        @(negedge clk);

        for (int p = 0; p < NRP; p++) begin
            got = bus.r_data_o[p*32 +: 32];
            if (!rst_v) begin
                sb[p].delete();
                last_data[p] = 32'h0;
                check("rst_valid", p, {31'h0, bus.r_valid_o[p]}, 32'h0);
                check("rst_data", p, got, 32'h0);
            end else if (sb[p].size() > 0 && sb[p][0].due == edge_cnt) begin
                check("rd_valid", p, {31'h0, bus.r_valid_o[p]}, 32'h1);
                check("rd_data", p, got, sb[p][0].data);
                last_data[p] = sb[p][0].data;
                void'(sb[p].pop_front());
            end else begin
                check("idle_valid", p, {31'h0, bus.r_valid_o[p]}, 32'h0);
                check("hold_data", p, got, last_data[p]);
            end
        end
        $display("[TB] edge %0d rst=%0b wen=%0b be=%h wa=%0d wd=%h ren=%b ra=%0d/%0d -> v=%b d0=%h d1=%h",
                 edge_cnt, rst_v, v.wen, v.be, v.wa, v.wd, v.ren, v.ra0, v.ra1,
                 bus.r_valid_o, bus.r_data_o[31:0], bus.r_data_o[63:32]);
    endtask

    localparam logic [11:0] OOR = 12'(MEM_NUM);

    initial begin
        vec_t idle;
        idle = mk(0, 4'h0, 12'd0, 32'h0, 2'b00, 12'd0, 12'd0, 2'b00, 32'h0, 32'h0);
        for (int p = 0; p < NRP; p++) last_data[p] = 32'h0;

        rst = 1'b0;
        bus.wen = 1'b0; bus.w_be_i = '0; bus.w_addr_i = '0; bus.w_data_i = '0;
        bus.ren = '0;   bus.r_addr_i = '0;

        tbl.push_back(mk(1, 4'hF, 12'd5, 32'hDEADBEEF, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 4'h0, 12'd0, 32'h0,        2'b01, 5, 0, 2'b01, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 4'hF, 12'd7, 32'h11223344, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 4'h5, 12'd7, 32'hAABBCCDD, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 4'h0, 12'd0, 32'h0,        2'b11, 7, 7, 2'b11, 32'h11BB33DD, 32'h11BB33DD));
        tbl.push_back(mk(1, 4'hF, 12'd9, 32'h11223344, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 4'h8, 12'd9, 32'hFF000000, 2'b11, 9, 9, 2'b11, 32'hFF223344, 32'hFF223344));
        tbl.push_back(mk(1, 4'hF, 12'd9, 32'h00000000, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 4'hF, 12'd0, 32'h0A0B0C0D, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 4'hF, OOR,   32'h12345678, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 4'h0, 12'd5, 32'h00000000, 2'b00, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 4'h0, 12'd0, 32'h0,        2'b11, 5, 0, 2'b11, 32'hDEADBEEF, 32'h0A0B0C0D));
        tbl.push_back(mk(0, 4'h0, 12'd0, 32'h0,        2'b01, OOR, 0, 2'b01, 32'h0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 4'h0, 12'd0, 32'h0, 2'b01, 9, 0, 2'b01, 32'h0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);

        // Reset held three edges with both ports requesting reads.
        for (int i = 0; i < 3; i++)
            step(1'b0, mk(1, 4'hF, 12'd3, 32'hCAFEF00D, 2'b11, 3, 3, 2'b00, 0, 0));

        foreach (tbl[i]) step(1'b1, tbl[i]);

        // Reset mid-stream: reads in flight on both ports, plus a write that must be ignored.
        step(1'b1, mk(0, 4'h0, 12'd0, 32'h0, 2'b11, 5, 7, 2'b00, 0, 0));
        step(1'b1, mk(0, 4'h0, 12'd0, 32'h0, 2'b11, 7, 5, 2'b00, 0, 0));
        step(1'b0, mk(1, 4'hF, 12'd5, 32'h0, 2'b11, 5, 7, 2'b00, 0, 0));
        step(1'b1, mk(0, 4'h0, 12'd0, 32'h0, 2'b11, 5, 7, 2'b11, 32'hDEADBEEF, 32'h11BB33DD));
        step(1'b1, idle);
        step(1'b1, idle);

        for (int p = 0; p < NRP; p++) check("sb_drained", p, sb[p].size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
